mul_div_unit: RTL

//  Iterative RV32M multiply/divide unit; parametrised multi-cycle companion to the single-cycle

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_iter_core.sv | 73 +++++++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op inside {OpRem, OpRemu};
  endfunction

  function automatic logic a_signed(input mdu_op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic b_signed(input mdu_op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iteration datapath: 2*XLEN accumulator plus one shared XLEN+1 bit adder.
// Multiply: {hi, lo} starts as {0, |a|}, shift-add of |b| on lo[0], shift right.
// Divide:   {rem, quo} starts as {0, |a|}, restoring shift-subtract of |b|, shift left.
module mdu_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_mode_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [XLEN-1:0]   b_mag_i,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              div_q, div_d;

  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     add_x, add_y;
  logic [XLEN+1:0]   sum;
  logic              no_borrow;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Shared adder: hi + b for multiply, ({hi, lo msb}) - b for divide.
  always_comb begin
    add_x     = div_q ? {hi, lo[XLEN-1]} : {1'b0, hi};
    add_y     = div_q ? ~{1'b0, b_q} : {1'b0, b_q};
    sum       = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN + 1){1'b0}}, div_q};
    no_borrow = sum[XLEN+1];
  end

  // Accumulator next state: load on accept, one step per cycle while iterating.
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_mag_i};
      b_d   = b_mag_i;
      div_d = div_mode_i;
    end else if (step_i) begin
      if (div_q) begin
        acc_d = {(no_borrow ? sum[XLEN-1:0] : add_x[XLEN-1:0]), lo[XLEN-2:0], no_borrow};
      end else if (lo[0]) begin
        acc_d = {sum[XLEN:0], lo[XLEN-1:1]};
      end else begin
        acc_d = {1'b0, hi, lo[XLEN-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  // The top latches the final value in the same edge as the last step.
  assign acc_next_o = acc_d;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake on both sides.
// Owns the FSM, operand sign handling, early-out detection and the result register.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_div_by_zero,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             dbz_q, dbz_d;

  mdu_op_e           op_in;
  logic              a_neg, b_neg, div_zero, div_ovf, accept, core_load, core_step;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] core_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fixed_res;

  // Request decode: operand magnitudes and early-out conditions.
  always_comb begin
    op_in    = mdu_op_e'(i_op);
    a_neg    = a_signed(op_in) & i_a[XLEN-1];
    b_neg    = b_signed(op_in) & i_b[XLEN-1];
    a_mag    = a_neg ? -i_a : i_a;
    b_mag    = b_neg ? -i_b : i_b;
    div_zero = is_div(op_in) && (i_b == '0);
    div_ovf  = (op_in inside {OpDiv, OpRem}) && (i_a == MinNeg) && (i_b == '1);
    accept   = (state_q == StIdle) && i_valid && !i_flush;
  end

  assign core_load = accept && !div_zero && !div_ovf;
  assign core_step = (state_q == StCalc);

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_iter_core (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (core_load),
    .step_i     (core_step),
    .div_mode_i (is_div(op_in)),
    .a_mag_i    (a_mag),
    .b_mag_i    (b_mag),
    .acc_next_o (core_next)
  );

  // Sign correction of the final magnitude result and result selection.
  always_comb begin
    prod_fix  = (sa_q ^ sb_q) ? -core_next : core_next;
    quo_fix   = (sa_q ^ sb_q) ? -core_next[XLEN-1:0] : core_next[XLEN-1:0];
    rem_fix   = sa_q ? -core_next[2*XLEN-1:XLEN] : core_next[2*XLEN-1:XLEN];
    fixed_res = '0;
    unique case (op_q)
      OpMul:                     fixed_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fixed_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fixed_res = quo_fix;
      default:                   fixed_res = rem_fix;
    endcase
  end

  // FSM next state; flush has priority over every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = op_in;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (div_zero) begin
            result_d = is_rem(op_in) ? i_a : '1;
            dbz_d    = 1'b1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = is_rem(op_in) ? '0 : i_a;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (i_flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = fixed_res;
          state_d  = StDone;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (i_flush || i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMul;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_ready       = (state_q == StIdle);
  assign o_busy        = (state_q != StIdle);
  assign o_valid       = (state_q == StDone);
  assign o_result      = o_valid ? result_q : '0;
  assign o_div_by_zero = o_valid & dbz_q;

endmodule
